// File: rtl/ser_pkg.sv
// ser_pkg: shared FSM state type and parameter defaults for bit_serializer
package ser_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_DATA_W    = 8;
  localparam bit DEF_MSB_FIRST = 1'b1;
  localparam bit DEF_IDLE_BIT  = 1'b0;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with a one-word skid so words stream back to back
module bit_serializer
  import ser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter bit MSB_FIRST = DEF_MSB_FIRST,
  parameter bit IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg, hold, shifted;
  logic              hold_full, xfer, last;
  assign in_ready  = !hold_full;
  assign xfer      = in_valid && in_ready;
  assign last      = state == SHIFT && cnt == CW'(DATA_W - 1);
  assign shifted   = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
  assign ser_valid = state == SHIFT;
  assign ser_last  = last;
  assign ser_out   = state == SHIFT ? (MSB_FIRST ? shreg[DATA_W-1] : shreg[0]) : IDLE_BIT;
  assign busy      = state == SHIFT || hold_full;
  // On the last-bit edge the next word (held first, else incoming) refills the shifter with no gap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (state == IDLE) begin
      if (xfer) begin
        state <= SHIFT;
        shreg <= in_data;
        cnt   <= '0;
      end
    end else if (last) begin
      cnt <= '0;
      if (hold_full) begin
        shreg     <= hold;
        hold_full <= 1'b0;
      end else if (xfer) shreg <= in_data;
      else state <= IDLE;
    end else begin
      shreg <= shifted;
      cnt   <= cnt + 1'b1;
      if (xfer) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of the serializer, MSB-first and LSB-first/idle-high variants
module tb_bit_serializer;
  logic       clk = 1'b0, rstn = 1'b0;
  logic [7:0] in_data = '0, in_data_b = '0;
  logic       in_valid = 1'b0, in_valid_b = 1'b0;
  logic       in_ready, ser_out, ser_valid, ser_last, busy;
  logic       b_in_ready, b_ser_out, b_ser_valid, b_ser_last, b_busy;
  int         n_checks = 0, n_err = 0;
  logic [63:0] acc, lastv;
  logic [2:0]  det;
  int          nbits, run, maxrun, hits;
  logic        clr = 1'b0;

  always #5 clk = ~clk;

  bit_serializer dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy)
  );

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .rstn(rstn), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(b_in_ready),
    .ser_out(b_ser_out), .ser_valid(b_ser_valid), .ser_last(b_ser_last), .busy(b_busy)
  );

  // stream recorder plus a 1101 sequence detector standing in for the downstream block
  always @(negedge clk) begin
    if (clr) begin
      acc <= '0; lastv <= '0; det <= '0;
      nbits <= 0; run <= 0; maxrun <= 0; hits <= 0;
    end else if (ser_valid) begin
      acc   <= {acc[62:0], ser_out};
      lastv <= {lastv[62:0], ser_last};
      det   <= {det[1:0], ser_out};
      if ({det, ser_out} == 4'b1101) hits <= hits + 1;
      nbits <= nbits + 1;
      run   <= run + 1;
      if (run + 1 > maxrun) maxrun <= run + 1;
    end else run <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  initial begin
    logic [7:0]  w [3];
    logic [15:0] accb;
    int          nb, i, stall;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    repeat (3) @(negedge clk);
    check("rst_ser_out", ser_out, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_last", ser_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("b_idle_bit", b_ser_out, 1);
    rstn = 1'b1;
    clear_mon();

    // single 0xD0, first bit one cycle after the accept edge
    @(negedge clk); in_data = 8'hD0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("lat_valid", ser_valid, 1);
    check("lat_bit", ser_out, 1);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("d0_bits", acc[7:0], 8'hD0);
    check("d0_count", nbits, 8);
    check("d0_last", lastv[7:0], 8'h01);
    check("d0_detect", hits, 1);
    check("idle_after", ser_out, 0);

    // LSB-first instance, 0x0B
    accb = '0; nb = 0;
    @(negedge clk); in_data_b = 8'h0B; in_valid_b = 1'b1;
    repeat (12) begin
      @(negedge clk);
      in_valid_b = 1'b0;
      if (b_ser_valid) begin
        accb = {accb[14:0], b_ser_out};
        nb++;
      end
    end
    check("b_bits", accb[7:0], 8'hD0);
    check("b_valid_cycles", nb, 8);

    // back to back 0xA5, 0x3C
    clear_mon();
    @(negedge clk); in_data = 8'hA5; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h3C;
    @(negedge clk);
    check("b2b_ready_held", in_ready, 0);
    check("b2b_busy", busy, 1);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("b2b_bits", acc[15:0], 16'hA53C);
    check("b2b_run", maxrun, 16);
    check("b2b_last", lastv[15:0], 16'h0101);

    // third word stalls while the holding register is full
    clear_mon();
    i = 0; stall = 0;
    repeat (40) begin
      @(negedge clk);
      if (i < 3) begin
        in_data = w[i]; in_valid = 1'b1;
        if (i == 2 && !in_ready) stall++;
        if (in_ready) i++;
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("three_accepted", i, 3);
    check("three_stall", stall, 7);
    check("three_bits", acc[23:0], 24'h112233);
    check("three_run", maxrun, 24);

    // reset after the third bit of 0xFF with 0x81 held
    clear_mon();
    @(negedge clk); in_data = 8'hFF; in_valid = 1'b1;
    @(negedge clk); in_data = 8'h81;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", ser_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_out", ser_out, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check("mid_rst_pre_bits", acc[2:0], 3'b111);
    check("mid_rst_no_more", nbits, 3);
    check("mid_rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter DATA_W, default 8, width in bits of each parallel word (minimum 2).
REQ-002 Parameter MSB_FIRST, default 1; 1 shifts bit DATA_W-1 first, 0 shifts bit 0 first.
REQ-003 Parameter IDLE_BIT, default 0, level driven on ser_out while no word is shifting.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  DATA_W  parallel word from the producer.
REQ-007 in_valid  input  1  producer has a word on in_data.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 ser_out  output  1  serial bit stream to the downstream sequence detector input.
REQ-010 ser_valid  output  1  ser_out carries a data bit this cycle.
REQ-011 ser_last  output  1  current ser_out bit is the final bit of its word.
REQ-012 busy  output  1  shifter active or holding register occupied.

Function
REQ-013 Transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; no other edge SHALL capture in_data.
REQ-014 Block SHALL contain a DATA_W-bit shift register, a bit counter (0..DATA_W-1) and a one-word holding register with a full flag.
REQ-015 FSM SHALL have two states: IDLE (shifter empty) and SHIFT (shifter outputting a word).
REQ-016 IDLE -> SHIFT on a transfer; the word loads directly into the shifter and the bit counter clears to 0.
REQ-017 In SHIFT, the shifter SHALL advance one bit and the counter SHALL increment by 1 each cycle.
REQ-018 On the last-bit edge (counter == DATA_W-1), a full holding register SHALL move into the shifter, clear its full flag and zero the counter; the FSM stays in SHIFT.
REQ-019 On the last-bit edge with the holding register empty and a transfer on the same edge, the new word SHALL load directly into the shifter; the FSM stays in SHIFT.
REQ-020 On the last-bit edge with the holding register empty and no transfer, the FSM SHALL return to IDLE.
REQ-021 A transfer while in SHIFT that is not on the last-bit edge SHALL write the holding register and set its full flag.
REQ-022 in_ready SHALL equal NOT hold_full, driven from registered state only, with no combinational path from in_valid.
REQ-023 Latency: the first bit of a word accepted at edge k SHALL appear on ser_out, with ser_valid=1, in the cycle following edge k.
REQ-024 Back-to-back words SHALL stream with zero idle cycles between them when the producer keeps in_valid high.
REQ-025 ser_out, ser_valid and ser_last SHALL be driven from registers or from decoded state only; none SHALL be a combinational function of in_data or in_valid.
REQ-026 In IDLE, ser_out SHALL equal IDLE_BIT and ser_valid and ser_last SHALL be 0.
REQ-027 ser_last SHALL be 1 exactly when ser_valid=1 and the counter == DATA_W-1.
REQ-028 busy SHALL equal (state==SHIFT) OR hold_full.

Reset
REQ-029 While rstn=0: state=IDLE, counter=0, hold_full=0, shift and holding registers=0.
REQ-030 While rstn=0: ser_out=IDLE_BIT, ser_valid=0, ser_last=0, busy=0, in_ready=1.
REQ-031 Reset asserted mid-word SHALL discard the partial word and any held word; no bit of either SHALL be emitted after reset release.

Structure
REQ-032 Package ser_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the default values of DATA_W, MSB_FIRST and IDLE_BIT.
REQ-033 Implementation SHALL be a single module with no sub-module; the holding register and the shifter are inline.

Verification
REQ-034 DATA_W=8, MSB_FIRST=1, single word 0xD0 -> ser_out 1,1,0,1,0,0,0,0 over 8 cycles; ser_last only on the 8th; downstream 1101 detector output pulses once.
REQ-035 MSB_FIRST=0, word 0x0B -> ser_out 1,1,0,1,0,0,0,0; ser_valid high for exactly 8 cycles.
REQ-036 Words 0xA5 then 0x3C with in_valid held high -> 16 consecutive ser_valid cycles with bits 10100101 00111100; in_ready low while the second word is held.
REQ-037 Third word presented while hold_full=1 -> in_ready=0 and the word is not captured until the first word's last-bit edge; no bit is lost or duplicated.
REQ-038 rstn pulsed low after the 3rd bit of 0xFF with 0x81 held -> ser_valid=0, busy=0, in_ready=1 immediately; no further bits until a new transfer.
